// File: rtl/ez8_pkg.sv
// Shared definitions for the ez8 execute stage: opcodes, instruction fields,
// the multiplier sequencing states and the status register address.
package ez8_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_MOVF   = 4'h1;
  localparam logic [3:0] OP_MOVWF  = 4'h2;
  localparam logic [3:0] OP_ADDWF  = 4'h3;
  localparam logic [3:0] OP_SUBWF  = 4'h4;
  localparam logic [3:0] OP_ANDWF  = 4'h5;
  localparam logic [3:0] OP_IORWF  = 4'h6;
  localparam logic [3:0] OP_XORWF  = 4'h7;
  localparam logic [3:0] OP_INCF   = 4'h8;
  localparam logic [3:0] OP_DECF   = 4'h9;
  localparam logic [3:0] OP_ADDWFC = 4'hA;
  localparam logic [3:0] OP_CLRF   = 4'hB;
  localparam logic [3:0] OP_MOVLW  = 4'hC;
  localparam logic [3:0] OP_ADDLW  = 4'hD;
  localparam logic [3:0] OP_MULWF  = 4'hE;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int D_BIT  = 11;
  localparam int F_MSB  = 7;
  localparam int F_LSB  = 0;

  localparam logic [7:0] STATUS_ADDR = 8'h01;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_LOAD,
    MUL_STEP,
    MUL_DONE
  } mul_state_t;

endpackage

// File: rtl/exec_stage_mul8_seq.sv
// Iterative 8x8 shift-add multiplier: start loads operands, then eight
// single-bit steps; done is high during the final step.
module mul8_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        done,
  output logic [15:0] product
);

  logic [7:0]  mcand;
  logic [15:0] prod;
  logic [2:0]  cnt;
  logic        running;
  logic [8:0]  sum9;

  // Upper half accumulates the partial sum while the multiplier shifts out of the lower half.
  assign sum9    = {1'b0, prod[15:8]} + (prod[0] ? {1'b0, mcand} : 9'h000);
  assign done    = running && (cnt == 3'd7);
  assign product = prod;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand   <= 8'h00;
      prod    <= 16'h0000;
      cnt     <= 3'd0;
      running <= 1'b0;
    end else if (start) begin
      mcand   <= a;
      prod    <= {8'h00, b};
      cnt     <= 3'd0;
      running <= 1'b1;
    end else if (running) begin
      prod <= {sum9, prod[7:1]};
      cnt  <= cnt + 3'd1;
      if (cnt == 3'd7) running <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Two-stage execute stage: E1 issues the read address, E2 computes and drives
// all mem_ctrl write-side ports combinationally; MULWF stalls issue.
module exec_stage
  import ez8_pkg::*;
#(
  parameter bit MUL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [7:0]  readaddr,
  input  logic [7:0]  readdata,
  input  logic [7:0]  accum_out,
  input  logic        cout,
  output logic [7:0]  writeaddr,
  output logic [7:0]  writedata,
  output logic        write_en,
  output logic [7:0]  accum_in,
  output logic        accum_write,
  output logic        zin,
  output logic        z_write,
  output logic        cin,
  output logic        c_write,
  output logic        retire_valid,
  output logic [3:0]  retire_op,
  output logic        illegal,
  output logic        busy
);

  mul_state_t  state, next_state;
  logic        e2_valid;
  logic [3:0]  e2_op;
  logic        e2_d;
  logic [7:0]  e2_f;
  logic [7:0]  mul_f;
  logic        accept, accept_mul, e2_is_mul;
  logic        mul_start, mul_commit, mul_done;
  logic [15:0] mul_product;
  logic [8:0]  alu;
  logic        wr_res, wr_acc, set_z, set_c;
  logic        unused_bits;

  assign unused_bits = ^instr_in[10:8];
  assign readaddr    = instr_in[F_MSB:F_LSB];
  assign accept      = instr_valid && instr_ready;
  assign accept_mul  = accept && MUL_EN && (instr_in[OP_MSB:OP_LSB] == OP_MULWF);
  assign e2_is_mul   = MUL_EN && (e2_op == OP_MULWF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e2_valid <= 1'b0;
      e2_op    <= OP_NOP;
      e2_d     <= 1'b0;
      e2_f     <= 8'h00;
    end else begin
      e2_valid <= accept;
      if (accept) begin
        e2_op <= instr_in[OP_MSB:OP_LSB];
        e2_d  <= instr_in[D_BIT];
        e2_f  <= instr_in[F_MSB:F_LSB];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= MUL_IDLE;
      mul_f <= 8'h00;
    end else begin
      state <= next_state;
      if (state == MUL_LOAD) mul_f <= e2_f;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      MUL_IDLE: if (accept_mul) next_state = MUL_LOAD;
      MUL_LOAD: next_state = MUL_STEP;
      MUL_STEP: if (mul_done) next_state = MUL_DONE;
      MUL_DONE: next_state = accept_mul ? MUL_LOAD : MUL_IDLE;
      default:  next_state = MUL_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == MUL_IDLE) || (state == MUL_DONE);
    busy        = (state == MUL_LOAD) || (state == MUL_STEP);
    mul_start   = (state == MUL_LOAD);
    mul_commit  = (state == MUL_DONE);
  end

  mul8_seq u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (accum_out),
    .b       (readdata),
    .done    (mul_done),
    .product (mul_product)
  );

  // A MULWF sitting in E2 only feeds the multiplier; its commit happens from DONE.
  always_comb begin
    writeaddr    = e2_f;
    writedata    = 8'h00;
    write_en     = 1'b0;
    accum_in     = 8'h00;
    accum_write  = 1'b0;
    zin          = 1'b0;
    z_write      = 1'b0;
    cin          = 1'b0;
    c_write      = 1'b0;
    retire_valid = 1'b0;
    retire_op    = e2_op;
    illegal      = 1'b0;
    alu          = 9'h000;
    wr_res       = 1'b0;
    wr_acc       = 1'b0;
    set_z        = 1'b0;
    set_c        = 1'b0;
    if (mul_commit) begin
      retire_valid = 1'b1;
      retire_op    = OP_MULWF;
      writeaddr    = mul_f;
      writedata    = mul_product[15:8];
      write_en     = 1'b1;
      accum_in     = mul_product[7:0];
      accum_write  = 1'b1;
      zin          = (mul_product == 16'h0000);
      z_write      = 1'b1;
    end else if (e2_valid && !e2_is_mul) begin
      retire_valid = 1'b1;
      unique case (e2_op)
        OP_NOP:    ;
        OP_MOVF:   begin alu = {1'b0, readdata}; wr_res = 1'b1; set_z = 1'b1; end
        OP_MOVWF:  begin write_en = 1'b1; writedata = accum_out; end
        OP_ADDWF:  begin
          alu = {1'b0, accum_out} + {1'b0, readdata};
          wr_res = 1'b1; set_z = 1'b1; set_c = 1'b1;
        end
        OP_SUBWF:  begin
          alu = {1'b0, readdata} - {1'b0, accum_out};
          alu[8] = ~alu[8];
          wr_res = 1'b1; set_z = 1'b1; set_c = 1'b1;
        end
        OP_ANDWF:  begin alu = {1'b0, accum_out & readdata}; wr_res = 1'b1; set_z = 1'b1; end
        OP_IORWF:  begin alu = {1'b0, accum_out | readdata}; wr_res = 1'b1; set_z = 1'b1; end
        OP_XORWF:  begin alu = {1'b0, accum_out ^ readdata}; wr_res = 1'b1; set_z = 1'b1; end
        OP_INCF:   begin alu = {1'b0, readdata + 8'h01}; wr_res = 1'b1; set_z = 1'b1; end
        OP_DECF:   begin alu = {1'b0, readdata - 8'h01}; wr_res = 1'b1; set_z = 1'b1; end
        OP_ADDWFC: begin
          alu = {1'b0, accum_out} + {1'b0, readdata} + {8'h00, cout};
          wr_res = 1'b1; set_z = 1'b1; set_c = 1'b1;
        end
        OP_CLRF:   begin alu = 9'h000; wr_res = 1'b1; set_z = 1'b1; end
        OP_MOVLW:  begin alu = {1'b0, e2_f}; wr_acc = 1'b1; end
        OP_ADDLW:  begin
          alu = {1'b0, accum_out} + {1'b0, e2_f};
          wr_acc = 1'b1; set_z = 1'b1; set_c = 1'b1;
        end
        default:   illegal = 1'b1;
      endcase
      if ((wr_res && !e2_d) || wr_acc) begin
        accum_write = 1'b1;
        accum_in    = alu[7:0];
      end
      if (wr_res && e2_d) begin
        write_en  = 1'b1;
        writedata = alu[7:0];
      end
      if (set_z) begin
        z_write = 1'b1;
        zin     = (alu[7:0] == 8'h00);
      end
      if (set_c) begin
        c_write = 1'b1;
        cin     = alu[8];
      end
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage with a small mem_ctrl environment model
// (registered read with write bypass, accumulator and carry registers).
module tb_exec_stage;

  logic        clk;
  logic        reset_n;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  readaddr;
  logic [7:0]  readdata;
  logic [7:0]  accum_out;
  logic        cout;
  logic [7:0]  writeaddr, writedata, accum_in;
  logic        write_en, accum_write;
  logic        zin, z_write, cin, c_write;
  logic        retire_valid, illegal, busy;
  logic [3:0]  retire_op;

  logic [7:0]  mem [256];
  logic        poke_en;
  logic [7:0]  poke_addr, poke_data, poke_acc;
  logic        poke_c;

  int total;
  int bad;

  typedef struct packed {
    logic [3:0] op;
    logic       ill;
    logic       aw;
    logic [7:0] ain;
    logic       we;
    logic [7:0] wa;
    logic [7:0] wd;
    logic       zw;
    logic       z;
    logic       cw;
    logic       c;
  } exp_t;

  exp_t exp_q[$];

  exec_stage #(.MUL_EN(1'b1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr_in     (instr_in),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .readaddr     (readaddr),
    .readdata     (readdata),
    .accum_out    (accum_out),
    .cout         (cout),
    .writeaddr    (writeaddr),
    .writedata    (writedata),
    .write_en     (write_en),
    .accum_in     (accum_in),
    .accum_write  (accum_write),
    .zin          (zin),
    .z_write      (z_write),
    .cin          (cin),
    .c_write      (c_write),
    .retire_valid (retire_valid),
    .retire_op    (retire_op),
    .illegal      (illegal),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment stand-in for mem_ctrl; pokes preload state while the DUT is idle.
  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_addr] <= poke_data;
      accum_out      <= poke_acc;
      cout           <= poke_c;
    end else begin
      if (write_en) mem[writeaddr] <= writedata;
      if (accum_write) accum_out <= accum_in;
      if (c_write) cout <= cin;
    end
    if (write_en && (writeaddr == readaddr)) readdata <= writedata;
    else readdata <= mem[readaddr];
  end

  function automatic exp_t mk(input logic [3:0] op, input logic ill,
                              input logic aw, input logic [7:0] ain,
                              input logic we, input logic [7:0] wa, input logic [7:0] wd,
                              input logic zw, input logic z, input logic cw, input logic c);
    exp_t e;
    e.op = op; e.ill = ill; e.aw = aw; e.ain = ain; e.we = we; e.wa = wa; e.wd = wd;
    e.zw = zw; e.z = z; e.cw = cw; e.c = c;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && retire_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_retire_op", {12'h0, retire_op}, 16'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("retire_op", {12'h0, retire_op}, {12'h0, e.op});
        checkOutput("illegal", {15'h0, illegal}, {15'h0, e.ill});
        checkOutput("accum_write", {15'h0, accum_write}, {15'h0, e.aw});
        checkOutput("write_en", {15'h0, write_en}, {15'h0, e.we});
        checkOutput("z_write", {15'h0, z_write}, {15'h0, e.zw});
        checkOutput("c_write", {15'h0, c_write}, {15'h0, e.cw});
        if (e.aw) checkOutput("accum_in", {8'h0, accum_in}, {8'h0, e.ain});
        if (e.we) checkOutput("mem_write", {writeaddr, writedata}, {e.wa, e.wd});
        if (e.zw) checkOutput("zin", {15'h0, zin}, {15'h0, e.z});
        if (e.cw) checkOutput("cin", {15'h0, cin}, {15'h0, e.c});
      end
    end else begin
      checkOutput("idle_enables", {11'h0, write_en, accum_write, z_write, c_write, illegal}, 16'h0000);
    end
  end

  task automatic setEnv(input logic [7:0] addr, input logic [7:0] data,
                        input logic [7:0] acc, input logic c);
    poke_en = 1'b1; poke_addr = addr; poke_data = data; poke_acc = acc; poke_c = c;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] instr, input exp_t e,
                               input bit expect_retire, output int waited);
    waited = 0;
    instr_in    = instr;
    instr_valid = 1'b1;
    if (expect_retire) exp_q.push_back(e);
    while (!instr_ready && waited < 32) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 32) checkOutput("issue_timeout", 16'(waited), 16'd0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w, low;
    total = 0; bad = 0;
    reset_n = 1'b0; instr_valid = 1'b0; instr_in = 16'h0000;
    poke_en = 1'b0; poke_addr = 8'h00; poke_data = 8'h00; poke_acc = 8'h00; poke_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", {15'h0, instr_ready}, 16'h1);
    checkOutput("reset_outputs", {10'h0, write_en, accum_write, retire_valid, illegal, busy, c_write}, 16'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] ADDWF wraps to zero with carry");
    setEnv(8'h20, 8'hFB, 8'h05, 1'b0);
    applyStimulus(16'h3020, mk(4'h3, 0, 1, 8'h00, 0, 8'h00, 8'h00, 1, 1, 1, 1), 1, w);

    $display("[TB] MOVLW / MOVWF / MOVF back to back");
    applyStimulus(16'hC03C, mk(4'hC, 0, 1, 8'h3C, 0, 8'h00, 8'h00, 0, 0, 0, 0), 1, w);
    applyStimulus(16'h2030, mk(4'h2, 0, 0, 8'h00, 1, 8'h30, 8'h3C, 0, 0, 0, 0), 1, w);
    checkOutput("movwf_issue_wait", 16'(w), 16'd0);
    applyStimulus(16'h1030, mk(4'h1, 0, 1, 8'h3C, 0, 8'h00, 8'h00, 1, 0, 0, 0), 1, w);
    checkOutput("movf_issue_wait", 16'(w), 16'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("env_mem30", {8'h0, mem[8'h30]}, 16'h003C);
    checkOutput("env_accum", {8'h0, accum_out}, 16'h003C);

    $display("[TB] MULWF 0x10 * 0x20");
    setEnv(8'h21, 8'h20, 8'h10, 1'b0);
    applyStimulus(16'hE021, mk(4'hE, 0, 1, 8'h00, 1, 8'h21, 8'h02, 1, 0, 0, 0), 1, w);
    checkOutput("mul_busy", {15'h0, busy}, 16'h1);
    low = 0;
    while (!instr_ready && low < 20) begin
      low++;
      @(posedge clk); #1;
    end
    checkOutput("mul_stall_cycles", 16'(low), 16'd9);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("env_mul_mem", {8'h0, mem[8'h21]}, 16'h0002);

    $display("[TB] reset during MULWF");
    setEnv(8'h22, 8'h33, 8'h07, 1'b0);
    applyStimulus(16'hE022, mk(4'hE, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0), 0, w);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #2;
    checkOutput("abort_enables", {14'h0, write_en, accum_write}, 16'h0);
    checkOutput("abort_ready", {15'h0, instr_ready}, 16'h1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("abort_mem22", {8'h0, mem[8'h22]}, 16'h0033);
    checkOutput("abort_accum", {8'h0, accum_out}, 16'h0007);
    checkOutput("post_reset_ready", {15'h0, instr_ready}, 16'h1);
    setEnv(8'h00, 8'h00, 8'h00, 1'b0);
    applyStimulus(16'hD001, mk(4'hD, 0, 1, 8'h01, 0, 8'h00, 8'h00, 1, 0, 1, 0), 1, w);

    $display("[TB] ADDWFC to memory with carry in");
    setEnv(8'h40, 8'h00, 8'hFF, 1'b1);
    applyStimulus(16'hA840, mk(4'hA, 0, 0, 8'h00, 1, 8'h40, 8'h00, 1, 1, 1, 1), 1, w);

    $display("[TB] CLRF status and INCF wrap");
    setEnv(8'h01, 8'hAA, 8'h12, 1'b0);
    applyStimulus(16'hB801, mk(4'hB, 0, 0, 8'h00, 1, 8'h01, 8'h00, 1, 1, 0, 0), 1, w);
    setEnv(8'h60, 8'hFF, 8'h12, 1'b0);
    applyStimulus(16'h8860, mk(4'h8, 0, 0, 8'h00, 1, 8'h60, 8'h00, 1, 1, 0, 0), 1, w);

    $display("[TB] reserved opcode then SUBWF with borrow");
    setEnv(8'h50, 8'h03, 8'h05, 1'b1);
    applyStimulus(16'hF000, mk(4'hF, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0), 1, w);
    applyStimulus(16'h4050, mk(4'h4, 0, 1, 8'hFE, 0, 8'h00, 8'h00, 1, 0, 1, 0), 1, w);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute stage directly upstream of mem_ctrl: accepts decoded 16-bit instructions and issues the register-file read address.
- Consumes readdata, accum_out and cout one cycle later, computes the ALU result, and drives every mem_ctrl write-side port (memory write, accumulator write, Z/C flag updates).
- Two-stage pipeline (E1 issue, E2 compute/commit) with one instruction per cycle, plus one iterative multi-cycle multiply that stalls issue.

Parameters:
- MUL_EN, 1, 1 = MULWF implemented; 0 = opcode 0xE treated as illegal.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- instr_in  in  16  [15:12] opcode, [11] d (0 = dest accum, 1 = dest mem), [7:0] f address or literal
- instr_valid  in  1  instr_in valid
- instr_ready  out  1  stage can accept; transfer when valid && ready
- readaddr  out  8  to mem_ctrl; combinational = instr_in[7:0]
- readdata  in  8  from mem_ctrl, valid the cycle after readaddr
- accum_out  in  8  current accumulator
- cout  in  1  current carry flag
- writeaddr / writedata / write_en  out  8/8/1  memory write
- accum_in / accum_write  out  8/1  accumulator write
- zin / z_write, cin / c_write  out  1/1 each  flag updates
- retire_valid  out  1  one-cycle pulse when an instruction commits
- retire_op  out  4  opcode of the retiring instruction
- illegal  out  1  one-cycle pulse when a reserved or disabled opcode retires
- busy  out  1  multiply in progress

Behaviour:
- Reset (async, any state including mid-multiply): E2 invalid, FSM IDLE, multiplier registers cleared. All write enables, retire_valid and illegal are 0; instr_ready = 1. An aborted multiply performs no write.
- Accept in cycle T: E2 register <= instr_in. Compute and commit in T+1. All write-side outputs are combinational from E2 + readdata + accum_out + cout, so mem_ctrl commits at the end of T+1.
- No forwarding logic: mem_ctrl read-after-write bypass plus same-edge accum/status update make back-to-back dependent instructions correct.
- res = result. dest: d = 0 -> accum_write; d = 1 -> write_en at writeaddr = f. Z = (res == 0).
- 0 NOP: nothing.
- 1 MOVF: res = mem; Z.
- 2 MOVWF: mem[f] <= accum; d ignored; no flags.
- 3 ADDWF: accum + mem; C = carry out; Z.
- 4 SUBWF: mem - accum; C = 1 when no borrow; Z.
- 5 ANDWF, 6 IORWF, 7 XORWF: bitwise op of accum and mem; Z only.
- 8 INCF: mem + 1; Z. 9 DECF: mem - 1; Z.
- A ADDWFC: accum + mem + cout; C; Z.
- B CLRF: res = 0; Z = 1.
- C MOVLW: accum <= literal; no flags.
- D ADDLW: accum + literal -> accum; C; Z.
- E MULWF (MUL_EN = 1): 16-bit product accum*mem. Low byte -> accum, high byte -> mem[f]. Z = (product == 0); C unchanged.
- F (and E when MUL_EN = 0): no writes; illegal pulses at retire.
- Flag enables: z_write / c_write asserted only for the ops listed above. A write to f = 0x01 (status) still drives flag enables; mem_ctrl gives the explicit write priority.
- MUL FSM (IDLE -> LOAD -> STEP -> DONE -> IDLE):
  - LOAD (T+1): latch multiplicand/multiplier and f; no writes, no retire.
  - STEP T+2..T+9: 8 shift-add iterations, 3-bit counter, 0..7.
  - DONE (T+10): commit and retire.
  - busy = 1 in LOAD and STEP. instr_ready = 0 from T+1 to T+9, 1 in DONE; an instruction may be accepted at T+10.
- instr_valid low: E2 goes invalid; no outputs asserted.

Decomposition:
- Shared package ez8_pkg: opcode constants OP_NOP..OP_MULWF, instruction field positions, STATUS_ADDR = 8'h01.
- One sub-module natural: mul8_seq, the iterative 8x8 shift-add multiplier with start/done handshake.

Test Plan:
- accum = 0x05, mem[0x20] = 0xFB, ADDWF d=0 f=0x20 -> T+1 accum_write, accum_in = 0x00, zin = 1, cin = 1, retire_valid = 1.
- MOVLW 0x3C, then back-to-back MOVWF 0x30, then MOVF d=0 0x30 -> mem[0x30] = 0x3C; accum reads 0x3C; Z = 0; throughput 1 per cycle.
- accum = 0x10, MULWF f=0x21 with mem[0x21] = 0x20 -> instr_ready low 9 cycles; at T+10 accum_in = 0x00, writedata = 0x02 at 0x21, Z = 0.
- Assert reset_n low at T+5 of a MULWF -> no write_en/accum_write; instr_ready = 1 after release; next ADDLW 0x01 to accum = 0x00 gives accum = 0x01.
- cout = 1, accum = 0xFF, mem = 0x00, ADDWFC d=1 f=0x40 -> writedata = 0x00, cin = 1, zin = 1.
- Opcode 0xF, then SUBWF with mem = 0x03, accum = 0x05 -> first gives illegal pulse and no writes; second gives res = 0xFE, cin = 0.
